// File: rtl/par_shift_ser_ctrl.sv
// Sequences an external par_shift_reg as a parallel-to-serial converter over valid/ready on both sides.
// Latency: word accepted at edge N gives first serial bit in cycle N+2; WIDTH+2 cycles per word (WIDTH+1 without clear).
// Backpressure: in_ready only in IDLE; ser_ready=0 freezes shift register and bit counter; abort drops the word.
module par_shift_ser_ctrl #(
   parameter int unsigned WIDTH       = 8,
   parameter logic        FILL_BIT    = 1'b0,
   parameter bit          CLEAR_AFTER = 1'b1
) (
   input  logic             clock,
   input  logic             aclr_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   input  logic             ser_ready,
   output logic             ser_valid,
   output logic             ser_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sr_data,
   output logic             sr_load,
   output logic             sr_enable,
   output logic             sr_sclr,
   output logic             sr_shiftin,
   input  logic             sr_shiftout
);

   localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_CLEAR = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;

   // State, bit counter and captured word; async clear returns everything to idle.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Next-state and control decode; abort in LOAD/SHIFT clears the register and wins over ser_ready.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      sr_load   = 1'b0;
      sr_enable = 1'b0;
      sr_sclr   = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // in_ready is held low while the async clear is asserted
            in_ready = aclr_n;
            if (in_valid && aclr_n) begin
               data_d  = in_data;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            sr_enable = 1'b1;
            cnt_d     = '0;
            if (abort) begin
               sr_sclr = 1'b1;
               state_d = S_IDLE;
            end else begin
               sr_load = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               sr_sclr   = 1'b1;
               sr_enable = 1'b1;
               cnt_d     = '0;
               state_d   = S_IDLE;
            end else begin
               ser_valid = 1'b1;
               sr_enable = ser_ready;
               if (ser_ready) begin
                  if (cnt_q == CNT_LAST) begin
                     done    = 1'b1;
                     cnt_d   = '0;
                     state_d = CLEAR_AFTER ? S_CLEAR : S_IDLE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
         end
         S_CLEAR: begin
            sr_sclr   = 1'b1;
            sr_enable = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ser_out    = ser_valid & sr_shiftout;
   assign busy       = (state_q != S_IDLE);
   assign sr_data    = data_q;
   assign sr_shiftin = FILL_BIT;

endmodule
